// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner ids and fetch byte enables.
package rv32i_mem_arbiter_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_WAIT = 1'b1;

  localparam logic ARB_OWN_IF = 1'b0;
  localparam logic ARB_OWN_D  = 1'b1;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/rv32i_starve_ctr.sv
// Saturating counter that tracks consecutive data grants taken while fetch is waiting.
module rv32i_starve_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] cnt_d;

  assign sat = (cnt == MaxVal);

  always_comb begin
    cnt_d = cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err_spurious
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic            state;
  logic            owner;
  logic [CntW-1:0] starve_cnt;
  logic            starve_sat;
  logic            idle;
  logic            win_d;
  logic            win_if;
  logic            cnt_inc;
  logic            cnt_clr;

  assign idle   = (state == ARB_IDLE);
  // starve_cnt < STARVE_MAX is exactly "not saturated"
  assign win_d  = d_req && !starve_sat;
  assign win_if = !win_d && if_req;

  assign d_gnt  = idle && win_d && mem_ready;
  assign if_gnt = idle && win_if && mem_ready;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = BE_WORD;
    mem_addr  = if_addr;
    mem_wdata = '0;
    if (idle) begin
      mem_req = if_req || d_req;
      if (win_d) begin
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
    end
  end

  assign if_rvalid = !idle && mem_rvalid && (owner == ARB_OWN_IF);
  assign d_rvalid  = !idle && mem_rvalid && (owner == ARB_OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign cnt_inc = d_gnt && if_req;
  assign cnt_clr = if_gnt || (d_gnt && !if_req);

  rv32i_starve_ctr #(
    .MAX (STARVE_MAX),
    .W   (CntW)
  ) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (starve_cnt),
    .sat   (starve_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      owner        <= ARB_OWN_IF;
      err_spurious <= 1'b0;
    end else begin
      if (idle) begin
        if (d_gnt) begin
          state <= ARB_WAIT;
          owner <= ARB_OWN_D;
        end else if (if_gnt) begin
          state <= ARB_WAIT;
          owner <= ARB_OWN_IF;
        end
        if (mem_rvalid) begin
          err_spurious <= 1'b1;
        end
      end else if (mem_rvalid) begin
        state <= ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: fetch, collision, starvation, backpressure, errors, reset.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err_spurious;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(
    .STARVE_MAX (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_be         (d_be),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .err_spurious (err_spurious)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_err", err_spurious, 0);
    check("rst_cnt", dut.starve_cnt, 0);
    check("rst_owner", dut.owner, 0);
    rst_n = 1'b1;
    tick();

    // Single fetch, response two cycles after grant
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    #1;
    check("f_if_gnt", if_gnt, 1);
    check("f_d_gnt", d_gnt, 0);
    check("f_mem_req", mem_req, 1);
    check("f_mem_addr", mem_addr, 32'h100);
    check("f_mem_we", mem_we, 0);
    check("f_mem_be", mem_be, 4'hF);
    tick();
    if_req = 1'b0;
    #1;
    check("f_wait_mem_req", mem_req, 0);
    check("f_wait_if_rvalid", if_rvalid, 0);
    check("f_wait_d_rvalid", d_rvalid, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    #1;
    check("f_if_rvalid", if_rvalid, 1);
    check("f_if_rdata", if_rdata, 32'h0050_0093);
    check("f_d_rvalid", d_rvalid, 0);
    tick();
    mem_rvalid = 1'b0;

    // Collision: store wins, fetch granted the cycle after the store's rvalid
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    #1;
    check("c_d_gnt", d_gnt, 1);
    check("c_if_gnt", if_gnt, 0);
    check("c_mem_we", mem_we, 1);
    check("c_mem_be", mem_be, 4'b0011);
    check("c_mem_addr", mem_addr, 32'h2000);
    check("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    #1;
    check("c_wait_if_gnt", if_gnt, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    #1;
    check("c_d_rvalid", d_rvalid, 1);
    check("c_if_rvalid", if_rvalid, 0);
    check("c_rv_if_gnt", if_gnt, 0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("c_if_gnt_after", if_gnt, 1);
    check("c_if_mem_addr", mem_addr, 32'h104);
    tick();
    mem_rvalid = 1'b1;
    #1;
    check("c_if_rvalid", if_rvalid, 1);
    tick();
    mem_rvalid = 1'b0;

    // Starvation: four data grants, one fetch grant, then data again
    d_req = 1'b1; d_addr = 32'h2004;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("s_d_gnt%0d", i), d_gnt, (i == 4) ? 0 : 1);
      check($sformatf("s_if_gnt%0d", i), if_gnt, (i == 4) ? 1 : 0);
      tick();
      if (i == 4) check("s_cnt_clear", dut.starve_cnt, 0);
      mem_rvalid = 1'b1;
      #1;
      check($sformatf("s_if_rv%0d", i), if_rvalid, (i == 4) ? 1 : 0);
      check($sformatf("s_d_rv%0d", i), d_rvalid, (i == 4) ? 0 : 1);
      tick();
      mem_rvalid = 1'b0;
    end
    d_req = 1'b0; if_req = 1'b0;

    // Backpressure: load held with mem_ready low for three cycles
    mem_ready = 1'b0; d_req = 1'b1; d_addr = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("b_d_gnt%0d", i), d_gnt, 0);
      check($sformatf("b_mem_req%0d", i), mem_req, 1);
      check($sformatf("b_state%0d", i), dut.state, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("b_d_gnt_ready", d_gnt, 1);
    tick();
    d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check("b_d_rvalid", d_rvalid, 1);
    check("b_d_rdata", d_rdata, 32'h1234_5678);
    tick();
    mem_rvalid = 1'b0;

    // Spurious response while idle
    check("sp_err_before", err_spurious, 0);
    mem_rvalid = 1'b1;
    #1;
    check("sp_if_rvalid", if_rvalid, 0);
    check("sp_d_rvalid", d_rvalid, 0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("sp_err_set", err_spurious, 1);
    tick();
    tick();
    check("sp_err_sticky", err_spurious, 1);

    // Reset in the middle of a fetch
    if_req = 1'b1; if_addr = 32'h200;
    #1;
    check("r_if_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("r_state", dut.state, 0);
    check("r_owner", dut.owner, 0);
    check("r_err", err_spurious, 0);
    check("r_mem_req", mem_req, 0);
    check("r_if_rvalid", if_rvalid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h204;
    #1;
    check("r2_if_gnt", if_gnt, 1);
    check("r2_mem_addr", mem_addr, 32'h204);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    check("r2_if_rvalid", if_rvalid, 1);
    check("r2_if_rdata", if_rdata, 32'h0000_0013);
    check("r2_d_rvalid", d_rvalid, 0);
    tick();
    mem_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
